// File: rtl/io_port_unit.sv
// I/O responder for the memory stage: services IN (input FIFO pop) and OUT (output register write).
// Latency: a pushed word is readable the cycle after its push edge; an OUT shows on out_valid after its edge.
// Backpressure: in_ready drops at full or in reset; io_stall is raised combinationally until the request can complete.

// Input queue used by the port unit: circular buffer with show-ahead head word.
// Latency: a word pushed at edge N appears on head_dat after edge N (no bypass).
// Backpressure: push_rdy is low at full and while reset is asserted; a pop on empty is ignored.
module io_port_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_vld,
   input  logic [WIDTH-1:0] push_dat,
   output logic             push_rdy,
   input  logic             pop_vld,
   output logic [WIDTH-1:0] head_dat,
   output logic             empty,
   output logic [PTR_W:0]   count
);
   // DEPTH is a power of two, so PTR_W-bit pointers wrap on their own.
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             push;
   logic             pop;

   assign full     = (count == FULL_COUNT);
   assign empty    = (count == '0);
   assign push_rdy = reset & ~full;
   assign push     = push_vld & push_rdy;
   assign pop      = pop_vld & ~empty;

   // Head word is read straight from storage; an empty queue reads as zero.
   assign head_dat = empty ? '0 : mem[rd_ptr];

   // Storage is not reset: the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // Pointer and occupancy tracking; a simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// Memory-stage I/O port unit: IN pops the input FIFO, OUT loads the output holding register.
// Latency: IN data is combinational in the request cycle; OUT data is registered (visible after the edge).
// Backpressure: io_stall holds the pipeline while the FIFO is empty (IN) or the output register is occupied (OUT).
module io_port_unit #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int PTR_W      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  io_en,
   input  logic                  io_rd,
   input  logic                  io_wr,
   input  logic [DATA_WIDTH-1:0] io_wdata,
   output logic [DATA_WIDTH-1:0] io_rdata,
   output logic                  io_stall,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PTR_W:0]        in_count
);
   logic rd_req;
   logic wr_req;
   logic fifo_empty;
   logic out_free;
   logic wr_accept;
   logic out_drain;

   // A read takes priority when both IN and OUT bits are set; the OUT is dropped, not stalled on.
   assign rd_req = io_en & io_rd;
   assign wr_req = io_en & io_wr & ~io_rd;

   // The holding register can take a new word if empty or if its current word leaves this cycle.
   assign out_free  = ~out_valid | out_ready;
   assign wr_accept = wr_req & out_free;
   assign out_drain = out_valid & out_ready;

   // A stalled request has no side effect: the FIFO ignores pops on empty, and wr_accept is low.
   assign io_stall = (rd_req & fifo_empty) | (wr_req & ~out_free);

   io_port_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH),
      .PTR_W (PTR_W)
   ) u_in_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_vld (in_valid),
      .push_dat (in_data),
      .push_rdy (in_ready),
      .pop_vld  (rd_req),
      .head_dat (io_rdata),
      .empty    (fifo_empty),
      .count    (in_count)
   );

   // Output holding register: load on an accepted OUT, otherwise clear valid once the sink takes the word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (wr_accept) begin
         out_valid <= 1'b1;
         out_data  <= io_wdata;
      end else if (out_drain) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench for io_port_unit: scoreboard queues hold expected IN and OUT words.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
// Prints one summary line with the vector and miscompare counts.
module tb_io_port_unit;
   logic        clk;
   logic        reset;
   logic        io_en;
   logic        io_rd;
   logic        io_wr;
   logic [15:0] io_wdata;
   logic [15:0] io_rdata;
   logic        io_stall;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  in_count;

   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] exp_q[$];
   logic [15:0] out_q[$];
   logic [15:0] want;
   logic        mvalid;

   io_port_unit #(.DATA_WIDTH(16), .FIFO_DEPTH(4), .PTR_W(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .io_en     (io_en),
      .io_rd     (io_rd),
      .io_wr     (io_wr),
      .io_wdata  (io_wdata),
      .io_rdata  (io_rdata),
      .io_stall  (io_stall),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .in_count  (in_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      io_en = 0; io_rd = 0; io_wr = 0; in_valid = 0;
   endtask

   task automatic test_reset();
      reset = 0; in_valid = 1; in_data = 16'h1234; io_en = 1; io_rd = 1; io_wr = 0;
      io_wdata = 0; out_ready = 0;
      #3;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      vectors++; if (io_rdata !== 16'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0000", io_rdata); end
      vectors++; if (io_stall !== 1'b1) begin miscompares++; $display("FAIL rst_stall: got %b want 1", io_stall); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      tick();
      vectors++; if (in_count !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", in_count); end
      reset = 1; idle_inputs();
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
      tick();
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1; in_data = 16'h1111 * 16'(i + 1);
         #1;
         vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready[%0d]: got %b want 1", i, in_ready); end
         exp_q.push_back(in_data);
         tick();
      end
      in_valid = 0;
      vectors++; if (in_count !== 3'(exp_q.size())) begin miscompares++; $display("FAIL fill_count: got %0d want %0d", in_count, exp_q.size()); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", in_ready); end
      in_valid = 1; in_data = 16'h5555;
      tick();
      in_valid = 0;
      vectors++; if (in_count !== 3'd4) begin miscompares++; $display("FAIL fifth_push: got count %0d want 4", in_count); end
      for (int i = 0; i < 4; i++) begin
         io_en = 1; io_rd = 1;
         #1;
         want = exp_q.pop_front();
         vectors++; if (io_stall !== 1'b0) begin miscompares++; $display("FAIL drain_stall[%0d]: got %b want 0", i, io_stall); end
         vectors++; if (io_rdata !== want) begin miscompares++; $display("FAIL drain_data[%0d]: got %h want %h", i, io_rdata, want); end
         tick();
      end
      #1;
      vectors++; if (io_stall !== 1'b1) begin miscompares++; $display("FAIL empty_stall: got %b want 1", io_stall); end
      vectors++; if (io_rdata !== 16'h0) begin miscompares++; $display("FAIL empty_rdata: got %h want 0000", io_rdata); end
      tick();
      idle_inputs();
      vectors++; if (in_count !== 3'd0) begin miscompares++; $display("FAIL drain_count: got %0d want 0", in_count); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1; in_data = 16'h0C01 + 16'(i);
         exp_q.push_back(in_data);
         tick();
      end
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; in_data = 16'hA000 + 16'(i); io_en = 1; io_rd = 1;
         #1;
         want = exp_q.pop_front();
         exp_q.push_back(in_data);
         vectors++; if (io_stall !== 1'b0) begin miscompares++; $display("FAIL wrap_stall[%0d]: got %b want 0", i, io_stall); end
         vectors++; if (io_rdata !== want) begin miscompares++; $display("FAIL wrap_data[%0d]: got %h want %h", i, io_rdata, want); end
         tick();
         vectors++; if (in_count !== 3'd3) begin miscompares++; $display("FAIL wrap_count[%0d]: got %0d want 3", i, in_count); end
      end
      in_valid = 0;
      while (exp_q.size() > 0) begin
         io_en = 1; io_rd = 1;
         #1;
         want = exp_q.pop_front();
         vectors++; if (io_rdata !== want) begin miscompares++; $display("FAIL wrap_tail: got %h want %h", io_rdata, want); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_empty_in();
      io_en = 1; io_rd = 1; in_valid = 1; in_data = 16'hBEEF;
      #1;
      vectors++; if (io_stall !== 1'b1) begin miscompares++; $display("FAIL empty_in_stall: got %b want 1", io_stall); end
      vectors++; if (io_rdata !== 16'h0) begin miscompares++; $display("FAIL empty_in_bypass: got %h want 0000", io_rdata); end
      exp_q.push_back(in_data);
      tick();
      in_valid = 0;
      #1;
      want = exp_q.pop_front();
      vectors++; if (io_stall !== 1'b0) begin miscompares++; $display("FAIL empty_in_stall2: got %b want 0", io_stall); end
      vectors++; if (io_rdata !== want) begin miscompares++; $display("FAIL empty_in_data: got %h want %h", io_rdata, want); end
      tick();
      idle_inputs();
      vectors++; if (in_count !== 3'd0) begin miscompares++; $display("FAIL empty_in_pop: got count %0d want 0", in_count); end
   endtask

   task automatic test_out_backpressure();
      out_ready = 0; io_en = 1; io_wr = 1; io_wdata = 16'h0055;
      #1;
      vectors++; if (io_stall !== 1'b0) begin miscompares++; $display("FAIL bp_first_stall: got %b want 0", io_stall); end
      tick();
      vectors++; if (out_valid !== 1'b1 || out_data !== 16'h0055) begin miscompares++; $display("FAIL bp_first: got v=%b d=%h want v=1 d=0055", out_valid, out_data); end
      io_wdata = 16'h0066;
      #1;
      vectors++; if (io_stall !== 1'b1) begin miscompares++; $display("FAIL bp_second_stall: got %b want 1", io_stall); end
      tick();
      vectors++; if (out_data !== 16'h0055) begin miscompares++; $display("FAIL bp_hold: got %h want 0055", out_data); end
      out_ready = 1;
      #1;
      vectors++; if (io_stall !== 1'b0) begin miscompares++; $display("FAIL bp_release_stall: got %b want 0", io_stall); end
      tick();
      io_en = 0; io_wr = 0;
      vectors++; if (out_valid !== 1'b1 || out_data !== 16'h0066) begin miscompares++; $display("FAIL bp_replace: got v=%b d=%h want v=1 d=0066", out_valid, out_data); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1; mvalid = 0;
      for (int i = 0; i < 6; i++) begin
         io_en = 1; io_wr = 1; io_wdata = 16'h0700 + 16'(i);
         #1;
         vectors++; if (io_stall !== 1'b0) begin miscompares++; $display("FAIL b2b_stall[%0d]: got %b want 0", i, io_stall); end
         vectors++; if (out_valid !== mvalid) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, out_valid, mvalid); end
         if (mvalid) begin
            want = out_q.pop_front();
            vectors++; if (out_data !== want) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h want %h", i, out_data, want); end
         end
         out_q.push_back(io_wdata);
         mvalid = 1;
         tick();
      end
      idle_inputs();
      want = out_q.pop_front();
      vectors++; if (out_valid !== 1'b1 || out_data !== want) begin miscompares++; $display("FAIL b2b_last: got v=%b d=%h want v=1 d=%h", out_valid, out_data, want); end
      tick();
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
   endtask

   task automatic test_decode();
      in_valid = 1; in_data = 16'h0D0D;
      exp_q.push_back(in_data);
      tick();
      in_valid = 0; io_en = 0; io_rd = 1; io_wr = 1; io_wdata = 16'h0BAD;
      #1;
      vectors++; if (io_stall !== 1'b0) begin miscompares++; $display("FAIL dec_off_stall: got %b want 0", io_stall); end
      tick();
      vectors++; if (in_count !== 3'd1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL dec_off_effect: got count=%0d v=%b want count=1 v=0", in_count, out_valid); end
      out_ready = 0; io_en = 1; io_rd = 0; io_wr = 1; io_wdata = 16'h00AA;
      tick();
      io_rd = 1; io_wr = 1; io_wdata = 16'h0BBB;
      #1;
      want = exp_q.pop_front();
      vectors++; if (io_stall !== 1'b0) begin miscompares++; $display("FAIL dec_both_stall: got %b want 0", io_stall); end
      vectors++; if (io_rdata !== want) begin miscompares++; $display("FAIL dec_both_data: got %h want %h", io_rdata, want); end
      tick();
      vectors++; if (in_count !== 3'd0 || out_data !== 16'h00AA || out_valid !== 1'b1) begin miscompares++; $display("FAIL dec_both_effect: got count=%0d d=%h v=%b want count=0 d=00aa v=1", in_count, out_data, out_valid); end
      #1;
      vectors++; if (io_stall !== 1'b1) begin miscompares++; $display("FAIL dec_both_empty_stall: got %b want 1", io_stall); end
      idle_inputs();
      out_ready = 1;
      tick();
      out_ready = 0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1; in_data = 16'h0E00 + 16'(i);
         tick();
      end
      in_valid = 0; io_en = 1; io_wr = 1; io_wdata = 16'h0077;
      tick();
      idle_inputs();
      #2;
      reset = 0;
      #1;
      vectors++; if (in_count !== 3'd0 || in_ready !== 1'b0 || io_rdata !== 16'h0) begin miscompares++; $display("FAIL mid_rst_fifo: got count=%0d rdy=%b d=%h want 0/0/0000", in_count, in_ready, io_rdata); end
      vectors++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin miscompares++; $display("FAIL mid_rst_out: got v=%b d=%h want v=0 d=0000", out_valid, out_data); end
      exp_q.delete();
      tick();
      reset = 1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_release: got %b want 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_empty_in();
      test_out_backpressure();
      test_back_to_back();
      test_decode();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
